// File: rtl/alu_seq_slice.sv
// alu_seq_slice: multi-cycle ALU that processes a WIDTH-bit operation one
// SLICE-bit slice per clock, LSB first, with a registered carry between slices.
// There is a valid/ready handshake on both sides, and one operation is in flight
// at a time.
module alu_seq_slice #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  // A partial last slice has no meaningful carry chain, so refuse to build one.
  if ((WIDTH % SLICE) != 0) begin : g_bad_width
    $error("alu_seq_slice: WIDTH must be a multiple of SLICE");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       s_q;
  logic             m_q;
  logic             carry_q;
  logic [IDXW-1:0]  idx_q;
  logic [WIDTH-1:0] result_q;
  logic             cout_q, zero_q, ovf_q, out_valid_q;

  logic [SLICE-1:0] a_sl_s, b_sl_s, y_sl_s, lg_sl_s, slice_res_s;
  logic [SLICE:0]   sum_s;
  logic             slice_cout_s;
  logic             ovf_d;
  logic [WIDTH-1:0] result_d;

  // Slice datapath: pick the current slice, form Y, then add or apply the logic function.
  always_comb begin
    a_sl_s = a_q[int'(idx_q)*SLICE +: SLICE];
    b_sl_s = b_q[int'(idx_q)*SLICE +: SLICE];
    case (s_q[1:0])
      2'b00:   y_sl_s = {SLICE{1'b0}};
      2'b01:   y_sl_s = b_sl_s;
      2'b10:   y_sl_s = ~b_sl_s;
      2'b11:   y_sl_s = {SLICE{1'b1}};
      default: y_sl_s = {SLICE{1'b0}};
    endcase
    sum_s = {1'b0, a_sl_s} + {1'b0, y_sl_s} + {{SLICE{1'b0}}, carry_q};
    lg_sl_s = {SLICE{1'b0}};
    for (int i = 0; i < SLICE; i++) begin
      lg_sl_s[i] = s_q[{a_sl_s[i], b_sl_s[i]}];
    end
    if (m_q) begin
      slice_res_s  = lg_sl_s;
      slice_cout_s = 1'b0;
      ovf_d        = 1'b0;
    end else begin
      slice_res_s  = sum_s[SLICE-1:0];
      slice_cout_s = sum_s[SLICE];
      // Only meaningful on the MSB slice, where these are the operand sign bits.
      ovf_d        = (a_sl_s[SLICE-1] == y_sl_s[SLICE-1]) &&
                     (sum_s[SLICE-1] != a_sl_s[SLICE-1]);
    end
    result_d = result_q;
    result_d[int'(idx_q)*SLICE +: SLICE] = slice_res_s;
  end

  // Control FSM plus all registered state and outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      s_q         <= 4'd0;
      m_q         <= 1'b0;
      carry_q     <= 1'b0;
      idx_q       <= {IDXW{1'b0}};
      result_q    <= {WIDTH{1'b0}};
      cout_q      <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            s_q     <= s;
            m_q     <= m;
            carry_q <= s[2] ? 1'b1 : cin;
            idx_q   <= {IDXW{1'b0}};
            state_q <= ST_BUSY;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          result_q <= result_d;
          carry_q  <= slice_cout_s;
          if (idx_q == LAST_IDX) begin
            idx_q       <= {IDXW{1'b0}};
            cout_q      <= slice_cout_s;
            zero_q      <= (result_d == {WIDTH{1'b0}});
            ovf_q       <= ovf_d;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            idx_q   <= idx_q + IDXW'(1);
            state_q <= ST_BUSY;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end else begin
            state_q <= ST_DONE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign cout      = cout_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;

endmodule
